trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//   Trap/return sequencer at the WB end of the 5-stage core. Detects a retiring instruction carrying
//   an exception/interrupt (exc fields piped from ID) or an MRET, flushes IF/ID/EX/MEM for a fixed
//   drain period, pulses the CSR updates (mepc/mcause/mstatus), then hands a redirect PC to IF
//   with a valid/ready handshake. Single owner of pipeline flush for traps.
// PARAMETERS
//   XLEN          32  datapath width
//   FLUSH_CYCLES  2   cycles trap_flush stays high before redirect (1..15)
// PORTS
//   clk              in   1     clock
//   rst              in   1     asynchronous, active-high reset
//   wb_valid         in   1     instruction retiring in WB this cycle
//   wb_pc            in   XLEN  PC of WB instruction
//   wb_exc_pending   in   1     WB instruction carries exception/interrupt
//   wb_exc_code      in   4     exception/interrupt cause code
//   wb_exc_interrupt in   1     cause is an interrupt
//   wb_mret          in   1     WB instruction is MRET
//   csr_mtvec        in   XLEN  current mtvec ([1:0]=mode)
//   csr_mepc         in   XLEN  current mepc
//   trap_flush       out  1     flush all upstream stages
//   trap_busy        out  1     state != IDLE
//   redirect_valid   out  1     redirect_pc valid to IF
//   redirect_ready   in   1     IF accepts redirect
//   redirect_pc      out  XLEN  new fetch PC
//   mepc_we          out  1     1-cycle pulse: write mepc_wdata
//   mepc_wdata       out  XLEN  = captured wb_pc
//   mcause_we        out  1     1-cycle pulse: write mcause_wdata
//   mcause_wdata     out  XLEN  {interrupt, {XLEN-5{0}}, code}
//   mstatus_trap     out  1     1-cycle pulse: MPIE<=MIE, MIE<=0
//   mstatus_mret     out  1     1-cycle pulse: MIE<=MPIE, MPIE<=1
// BEHAVIOUR
//   - Reset: state IDLE, counter 0, all outputs 0 (redirect_pc, *_wdata = 0). Reset mid-sequence
//     aborts immediately; no pending CSR pulse or redirect survives.
//   - IDLE: trigger = wb_valid & (wb_exc_pending | wb_mret). Exception wins if both set (treated as
//     trap, mstatus_mret not pulsed). On trigger capture pc/code/interrupt/kind, -> FLUSH next cycle.
//     Inputs with wb_valid=0 ignored.
//   - FLUSH: trap_flush=1 for exactly FLUSH_CYCLES cycles (down-counter loaded FLUSH_CYCLES-1).
//     First FLUSH cycle only: trap -> mepc_we, mcause_we, mstatus_trap; mret -> mstatus_mret.
//     Redirect target registered on entry. Counter==0 -> REDIRECT.
//   - REDIRECT: redirect_valid=1, trap_flush=1, redirect_pc stable until redirect_valid&redirect_ready;
//     that cycle -> IDLE (redirect_valid low next cycle). No timeout.
//   - Target: mret -> csr_mepc sampled at trigger. Trap: base={csr_mtvec[XLEN-1:2],2'b00};
//     mode==1 & interrupt -> base + (code<<2) (XLEN wrap, no carry-out); else base. Modes 2/3 = direct.
//   - Triggers while trap_busy ignored (WB contents are flushed younger instrs).
//   - Latency: trigger cycle T; flush T+1..; earliest redirect handshake at T+1+FLUSH_CYCLES.
//   - trap_busy = (state != IDLE); trap_flush low in IDLE.
// TESTING
//   1 Illegal instr: wb_pc=0x100,code=2,int=0,mtvec=0x800 -> flush 2 cyc, mepc=0x100,
//     mcause=0x2, mstatus_trap 1 pulse, redirect_pc=0x800.
//   2 Vectored IRQ: mtvec=0x801,code=7,int=1 -> redirect_pc=0x81C, mcause=0x80000007.
//   3 MRET: csr_mepc=0x2040 -> mstatus_mret pulse only, no mepc/mcause_we, redirect_pc=0x2040.
//   4 redirect_ready low 5 cycles -> redirect_valid/pc/flush held, single IDLE return on accept.
//   5 Second trigger during FLUSH, and exc+mret same cycle -> ignored / trap path only.
//   6 rst asserted during REDIRECT -> all outputs 0 same cycle, IDLE; next trigger works normally.

Source files
------------

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Trap/return sequencer at the WB end of the pipeline. Catches
//                a retiring exception/interrupt or MRET. It then flushes the
//                upstream stages for a fixed drain period and pulses the CSR
//                updates. Finally it hands a redirect PC to IF through a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic            wb_exc_pending_i,
    input  logic [3:0]      wb_exc_code_i,
    input  logic            wb_exc_interrupt_i,
    input  logic            wb_mret_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    output logic            trap_flush_o,
    output logic            trap_busy_o,
    output logic            redirect_valid_o,
    input  logic            redirect_ready_i,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            mepc_we_o,
    output logic [XLEN-1:0] mepc_wdata_o,
    output logic            mcause_we_o,
    output logic [XLEN-1:0] mcause_wdata_o,
    output logic            mstatus_trap_o,
    output logic            mstatus_mret_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    // Counter starts here so that FLUSH lasts exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] C_CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [3:0]        code_q, code_d;
    logic              irq_q, irq_d;
    logic              mret_q, mret_d;
    logic [XLEN-1:0]   target_q, target_d;

    logic              w_trigger;
    logic              w_is_mret;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_vec_off;
    logic [XLEN-1:0]   w_target;

    // An exception takes priority over an MRET retiring in the same slot.
    assign w_trigger = wb_valid_i & (wb_exc_pending_i | wb_mret_i);
    assign w_is_mret = wb_mret_i & ~wb_exc_pending_i;

    // Only mode 1 with an interrupt is vectored. Modes 0, 2 and 3 jump to the base.
    assign w_base    = {csr_mtvec_i[XLEN-1:2], 2'b00};
    assign w_vec_off = {{(XLEN-6){1'b0}}, wb_exc_code_i, 2'b00};
    assign w_target  = w_is_mret ? csr_mepc_i :
                       ((csr_mtvec_i[1:0] == 2'b01) && wb_exc_interrupt_i) ? (w_base + w_vec_off) :
                       w_base;

    // CSR write data and redirect PC come straight from the captured registers.
    assign mepc_wdata_o   = pc_q;
    assign mcause_wdata_o = {irq_q, {(XLEN-5){1'b0}}, code_q};
    assign redirect_pc_o  = target_q;

    // State and capture registers; reset aborts any sequence at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            pc_q     <= '0;
            code_q   <= 4'd0;
            irq_q    <= 1'b0;
            mret_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            code_q   <= code_d;
            irq_q    <= irq_d;
            mret_q   <= mret_d;
            target_q <= target_d;
        end
    end

    // Next-state, capture and output decode.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pc_d             = pc_q;
        code_d           = code_q;
        irq_d            = irq_q;
        mret_d           = mret_q;
        target_d         = target_q;
        trap_flush_o     = 1'b0;
        trap_busy_o      = 1'b0;
        redirect_valid_o = 1'b0;
        mepc_we_o        = 1'b0;
        mcause_we_o      = 1'b0;
        mstatus_trap_o   = 1'b0;
        mstatus_mret_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    state_d  = S_FLUSH;
                    cnt_d    = C_CNT_LOAD;
                    pc_d     = wb_pc_i;
                    code_d   = wb_exc_code_i;
                    irq_d    = wb_exc_interrupt_i;
                    mret_d   = w_is_mret;
                    target_d = w_target;
                end
            end
            S_FLUSH: begin
                trap_flush_o = 1'b1;
                trap_busy_o  = 1'b1;
                // The counter still holds its load value only in the first flush cycle.
                if (cnt_q == C_CNT_LOAD) begin
                    mepc_we_o      = ~mret_q;
                    mcause_we_o    = ~mret_q;
                    mstatus_trap_o = ~mret_q;
                    mstatus_mret_o = mret_q;
                end
                if (cnt_q == 4'd0) begin
                    state_d = S_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_REDIRECT: begin
                trap_flush_o     = 1'b1;
                trap_busy_o      = 1'b1;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Self-checking bench for trap_ctrl. It runs directed scenarios
//                and then random traffic. A timeline-based reference model
//                supplies the expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int C_FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_exc_pending, wb_exc_interrupt, wb_mret, redirect_ready;
    logic [31:0] wb_pc, csr_mtvec, csr_mepc;
    logic [3:0]  wb_exc_code;
    logic        trap_flush, trap_busy, redirect_valid;
    logic        mepc_we, mcause_we, mstatus_trap, mstatus_mret;
    logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding sequence, indexed by cycles since trigger.
    bit          m_active;
    int          m_k;
    logic [31:0] m_pc, m_target;
    logic [3:0]  m_code;
    logic        m_irq, m_mret;

    trap_ctrl #(.XLEN(32), .FLUSH_CYCLES(C_FC)) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_valid_i         (wb_valid),
        .wb_pc_i            (wb_pc),
        .wb_exc_pending_i   (wb_exc_pending),
        .wb_exc_code_i      (wb_exc_code),
        .wb_exc_interrupt_i (wb_exc_interrupt),
        .wb_mret_i          (wb_mret),
        .csr_mtvec_i        (csr_mtvec),
        .csr_mepc_i         (csr_mepc),
        .trap_flush_o       (trap_flush),
        .trap_busy_o        (trap_busy),
        .redirect_valid_o   (redirect_valid),
        .redirect_ready_i   (redirect_ready),
        .redirect_pc_o      (redirect_pc),
        .mepc_we_o          (mepc_we),
        .mepc_wdata_o       (mepc_wdata),
        .mcause_we_o        (mcause_we),
        .mcause_wdata_o     (mcause_wdata),
        .mstatus_trap_o     (mstatus_trap),
        .mstatus_mret_o     (mstatus_mret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic exc, input logic [3:0] code,
                         input logic irq, input logic mret, input logic [31:0] mtvec,
                         input logic [31:0] mepc, input logic rdy);
        wb_valid         = v;
        wb_pc            = pc;
        wb_exc_pending   = exc;
        wb_exc_code      = code;
        wb_exc_interrupt = irq;
        wb_mret          = mret;
        csr_mtvec        = mtvec;
        csr_mepc         = mepc;
        redirect_ready   = rdy;
    endtask

    function automatic logic [31:0] calc_target(input logic mret, input logic [31:0] mtvec,
                                                input logic [31:0] mepc, input logic irq,
                                                input logic [3:0] code);
        logic [31:0] base;
        if (mret) return mepc;
        base = mtvec & 32'hFFFF_FFFC;
        if (mtvec[1:0] == 2'd1 && irq) return base + 32'(code) * 32'd4;
        return base;
    endfunction

    // Model update with the inputs present at the clock edge.
    task automatic model_update();
        if (m_active) begin
            if (m_k > C_FC && redirect_ready) m_active = 1'b0;
            else m_k++;
        end else if (wb_valid && (wb_exc_pending || wb_mret)) begin
            m_active = 1'b1;
            m_k      = 1;
            m_pc     = wb_pc;
            m_code   = wb_exc_code;
            m_irq    = wb_exc_interrupt;
            m_mret   = wb_mret && !wb_exc_pending;
            m_target = calc_target(m_mret, csr_mtvec, csr_mepc, m_irq, m_code);
        end
    endtask

    task automatic compare();
        logic first, rv;
        first = m_active && (m_k == 1);
        rv    = m_active && (m_k > C_FC);
        check("trap_flush",     32'(trap_flush),     32'(m_active));
        check("trap_busy",      32'(trap_busy),      32'(m_active));
        check("redirect_valid", 32'(redirect_valid), 32'(rv));
        check("mepc_we",        32'(mepc_we),        32'(first && !m_mret));
        check("mcause_we",      32'(mcause_we),      32'(first && !m_mret));
        check("mstatus_trap",   32'(mstatus_trap),   32'(first && !m_mret));
        check("mstatus_mret",   32'(mstatus_mret),   32'(first && m_mret));
        if (rv) check("redirect_pc", redirect_pc, m_target);
        if (first && !m_mret) begin
            check("mepc_wdata",   mepc_wdata,   m_pc);
            check("mcause_wdata", mcause_wdata, (m_irq ? 32'h8000_0000 : 32'h0) | 32'(m_code));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flush"},  32'(trap_flush),     32'h0);
        check({tag, "_busy"},   32'(trap_busy),      32'h0);
        check({tag, "_rvalid"}, 32'(redirect_valid), 32'h0);
        check({tag, "_rpc"},    redirect_pc,         32'h0);
        check({tag, "_we"},     32'({mepc_we, mcause_we, mstatus_trap, mstatus_mret}), 32'h0);
        check({tag, "_mepcd"},  mepc_wdata,          32'h0);
        check({tag, "_mcaused"},mcause_wdata,        32'h0);
    endtask

    task automatic idle_steps(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            wb_valid       = 1'b0;
            redirect_ready = rdy;
            step();
        end
    endtask

    initial begin
        m_active = 1'b0;
        m_k      = 0;
        rst      = 1'b1;
        drive(0, 32'h0, 0, 4'h0, 0, 0, 32'h0, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        #2 rst = 1'b0;

        // Illegal instruction, direct mode.
        drive(1, 32'h100, 1, 4'd2, 0, 0, 32'h800, 32'h0, 1);
        step();
        idle_steps(4, 1);

        // Vectored interrupt: 0x800 + 7*4.
        drive(1, 32'h200, 1, 4'd7, 1, 0, 32'h801, 32'h0, 0);
        step();
        idle_steps(C_FC + 1, 0);
        check("vec_irq_pc", redirect_pc, 32'h81C);
        idle_steps(2, 1);

        // MRET returns to mepc.
        drive(1, 32'h300, 0, 4'd0, 0, 1, 32'h800, 32'h2040, 1);
        step();
        idle_steps(4, 1);

        // Ready held low five cycles in REDIRECT.
        drive(1, 32'h400, 1, 4'd11, 0, 0, 32'h1000, 32'h0, 0);
        step();
        idle_steps(C_FC + 5, 0);
        idle_steps(3, 1);

        // Retrigger during FLUSH is ignored; exc+mret together takes the trap path.
        drive(1, 32'h500, 1, 4'd3, 0, 1, 32'h900, 32'h7777, 1);
        step();
        drive(1, 32'h600, 0, 4'd0, 0, 1, 32'h900, 32'h8888, 1);
        step();
        idle_steps(4, 1);

        // Asynchronous reset in REDIRECT, then a normal trap.
        drive(1, 32'h700, 1, 4'd5, 0, 0, 32'hA00, 32'h0, 0);
        step();
        idle_steps(C_FC + 2, 0);
        #2 rst = 1'b1;
        #1;
        check_zero("midrst");
        m_active = 1'b0;
        #1 rst = 1'b0;
        drive(1, 32'h740, 1, 4'd4, 0, 0, 32'hB00, 32'h0, 1);
        step();
        idle_steps(4, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 3) == 0, $urandom, $urandom % 2, 4'($urandom), $urandom % 2,
                  ($urandom % 3) == 0, $urandom, $urandom, $urandom % 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
